calc_entry_sequencer: RTL
=========================

Name: calc_entry_sequencer

Overview:
Parametrised keypad-entry and execution sequencer for the FPGA calculator; successor of the fixed two-digit, single-operation top-level FSM. It collects two BCD operands of up to DIGITS digits plus an operation code and hands them to the downstream conversion/ALU path with a start/done handshake. It also drives display digits, blanking and status LEDs, chains results into the next operation, and includes an execution watchdog.

Parameters:
DIGITS, 2, max digits per operand; BCD buses are 4*DIGITS wide
OP_W, 3, operation code width
TIMEOUT, 1024, max cycles in EXEC waiting for i_Done before ERROR
TO_W, 11, watchdog counter width; must satisfy 2^TO_W > TIMEOUT

Ports:
i_Clk  in  1  system clock
i_Reset  in  1  reset, asynchronous, active-high
i_Key_Valid  in  1  one-cycle debounced digit-key pulse
i_Key_Code  in  4  digit value 0-9; sampled with i_Key_Valid; codes 10-15 ignored
i_Op_Valid  in  1  one-cycle operation-key pulse
i_Op_Code  in  OP_W  operation selector; 0 is illegal and ignored
i_Equals  in  1  one-cycle equals pulse
i_Clear  in  1  one-cycle clear pulse
i_Done  in  1  downstream result valid, one-cycle pulse
i_Result  in  4*DIGITS  BCD result, valid with i_Done
i_Overflow  in  1  downstream overflow flag, valid with i_Done
o_Operand_A  out  4*DIGITS  BCD operand A, stable from o_Start until i_Done
o_Operand_B  out  4*DIGITS  BCD operand B, same stability rule
o_Op_Code  out  OP_W  latched operation
o_Start  out  1  one-cycle pulse requesting execution
o_Display  out  4*DIGITS  BCD digits for the 7-segment decoders
o_Blank  out  DIGITS  per-digit blank; 1 = segment off
o_Status  out  4  one-hot state indicator for the LEDs
o_Error  out  1  high while in ERROR

Behaviour:
- Reset (async assert, sync-released use): state IDLE. All BCD outputs 0. o_Op_Code 0. o_Start 0. o_Blank all 1. o_Status 4'b0000. o_Error 0. Digit counters 0. Watchdog 0.
- States: IDLE, ENTRY_A, OP_WAIT, ENTRY_B, EXEC, SHOW, ERROR.
- Digit entry (ENTRY_A/ENTRY_B): the new digit shifts in at the least significant nibble and existing digits move up one nibble. The count increments, saturating at DIGITS. Once DIGITS digits are entered, further digits are ignored and the operand is unchanged.
- Leading zero: key 0 in IDLE or OP_WAIT is ignored and does not change state.
- IDLE: digit 1-9 loads A, then go to ENTRY_A. All other events are ignored.
- ENTRY_A: digit shifts into A. Legal i_Op_Valid latches the op and goes to OP_WAIT. i_Equals is ignored.
- OP_WAIT: display is blank. Digit 1-9 loads B, then go to ENTRY_B. A new legal op overwrites o_Op_Code.
- ENTRY_B: digit shifts into B. i_Equals pulses o_Start on the next cycle and goes to EXEC.
- EXEC: input keys are ignored. On i_Done:
  - i_Overflow=0: capture i_Result into o_Display and go to SHOW.
  - i_Overflow=1: go to ERROR.
- EXEC watchdog: counts cycles; reaching TIMEOUT goes to ERROR. The watchdog clears on leaving EXEC.
- SHOW: a legal op copies the result into A (digit count = number of significant digits), latches the op, and goes to OP_WAIT. A digit 1-9 starts a fresh A in ENTRY_A.
- ERROR: o_Error=1, display blank. Only i_Clear or reset exits.
- i_Clear in any state: next cycle returns to IDLE with reset values. Clear has priority over every simultaneous event, including i_Done.
- Simultaneous digit and op in the same cycle: the op wins and the digit is dropped.
- o_Display shows the operand currently being entered, right-aligned. Positions above the entered count are blanked; a result in SHOW has its leading zeros blanked, with at least one digit shown.
- o_Status: ENTRY_A=0001, OP_WAIT/ENTRY_B=0010, EXEC=0100, SHOW=1000, ERROR=1111, IDLE=0000.
- Latency: key pulse to updated o_Display is 1 cycle; i_Equals to o_Start is 1 cycle.

Optional Feature:
- Macro: CALC_BACKSPACE_EN.
- Defined: adds input port i_Back (1-bit pulse). In ENTRY_A/ENTRY_B, i_Back shifts the operand right one nibble, zero-fills the top nibble and decrements the count.
  - Count reaching 0 returns to IDLE (from ENTRY_A) or OP_WAIT (from ENTRY_B).
  - i_Back is ignored in all other states. If i_Back coincides with a digit, backspace wins.
- Undefined: no port and no backspace logic.

Test Plan:
- DIGITS=2. Keys 0,4,2, op=1, keys 1,7, equals -> A=0x42, B=0x17, o_Op_Code=1, o_Start pulses once 1 cycle after equals, o_Status=0100.
- Keys 1,2,3 in ENTRY_A -> A=0x12 (third digit ignored); o_Blank=00.
- EXEC, i_Done with i_Result=0x05, i_Overflow=0 -> o_Display=0x05, o_Blank=10, SHOW. Then op=2 -> A=0x05, OP_WAIT.
- EXEC with no i_Done for TIMEOUT=16 cycles -> ERROR, o_Error=1, o_Status=1111. Then i_Clear -> IDLE, all outputs at reset values.
- i_Clear and i_Done in the same cycle -> IDLE; result discarded. Async i_Reset asserted mid-ENTRY_B -> outputs reset immediately, without a clock edge.
- CALC_BACKSPACE_EN: keys 3,8, back, back -> A=0x00, state IDLE; back in OP_WAIT has no effect.

Source files
------------

// File: rtl/calc_entry_sequencer.sv
//------------------------------------------------------------------------------
// Module   : calc_entry_sequencer
// Purpose  : Keypad entry and execution sequencer for the calculator. Collects
//            two BCD operands and an operation, hands them to the downstream
//            ALU path with a start/done handshake, drives display/blank/status,
//            chains results into the next operation and guards EXEC with a
//            watchdog.
// Options  : define CALC_BACKSPACE_EN to add the i_Back backspace key.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module calc_entry_sequencer #(
  parameter int DIGITS  = 2,
  parameter int OP_W    = 3,
  parameter int TIMEOUT = 1024,
  parameter int TO_W    = 11
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset,
  input  logic                  i_Key_Valid,
  input  logic [3:0]            i_Key_Code,
  input  logic                  i_Op_Valid,
  input  logic [OP_W-1:0]       i_Op_Code,
  input  logic                  i_Equals,
  input  logic                  i_Clear,
`ifdef CALC_BACKSPACE_EN
  input  logic                  i_Back,
`endif
  input  logic                  i_Done,
  input  logic [4*DIGITS-1:0]   i_Result,
  input  logic                  i_Overflow,
  output logic [4*DIGITS-1:0]   o_Operand_A,
  output logic [4*DIGITS-1:0]   o_Operand_B,
  output logic [OP_W-1:0]       o_Op_Code,
  output logic                  o_Start,
  output logic [4*DIGITS-1:0]   o_Display,
  output logic [DIGITS-1:0]     o_Blank,
  output logic [3:0]            o_Status,
  output logic                  o_Error
);

  localparam int                W         = 4 * DIGITS;
  localparam int                CNT_W     = $clog2(DIGITS + 1);
  localparam logic [CNT_W-1:0]  C_FULL    = CNT_W'(DIGITS);
  localparam logic [TO_W-1:0]   C_TO_LAST = TO_W'(TIMEOUT - 1);
`ifdef CALC_BACKSPACE_EN
  localparam logic [CNT_W-1:0]  C_ONE     = CNT_W'(1);
`endif

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTRY_A = 3'd1,
    S_OP_WAIT = 3'd2,
    S_ENTRY_B = 3'd3,
    S_EXEC    = 3'd4,
    S_SHOW    = 3'd5,
    S_ERROR   = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic [W-1:0]        a_q, a_d;
  logic [W-1:0]        b_q, b_d;
  logic [W-1:0]        res_q, res_d;
  logic [W-1:0]        disp_q, disp_d;
  logic [CNT_W-1:0]    cnt_a_q, cnt_a_d;
  logic [CNT_W-1:0]    cnt_b_q, cnt_b_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic                start_q, start_d;
  logic                err_q, err_d;
  logic [DIGITS-1:0]   blank_q, blank_d;
  logic [3:0]          status_q, status_d;
  logic [TO_W-1:0]     wd_q, wd_d;

  logic                w_op_legal;
  logic                w_digit;
  logic                w_digit_nz;
  logic [W-1:0]        w_key_ext;

  // Blank every digit position at or above the number of entered digits.
  function automatic logic [DIGITS-1:0] f_blank_above(input logic [CNT_W-1:0] cnt);
    logic [DIGITS-1:0] b;
    b = '0;
    for (int i = 0; i < DIGITS; i++) begin
      b[i] = (i >= int'(cnt));
    end
    return b;
  endfunction

  // Blank leading zeros of a result, always keeping the units digit lit.
  function automatic logic [DIGITS-1:0] f_blank_lz(input logic [W-1:0] v);
    logic [DIGITS-1:0] b;
    logic              seen;
    b    = '0;
    seen = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (v[4*i +: 4] != 4'd0) seen = 1'b1;
      b[i] = !seen;
    end
    b[0] = 1'b0;
    return b;
  endfunction

  // Number of significant digits in a BCD value (0 for a zero value).
  function automatic logic [CNT_W-1:0] f_sig_digits(input logic [W-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] != 4'd0) n = CNT_W'(i + 1);
    end
    return n;
  endfunction

  // A legal op suppresses a digit arriving in the same cycle.
  assign w_op_legal = i_Op_Valid && (i_Op_Code != '0);
  assign w_digit    = i_Key_Valid && (i_Key_Code <= 4'd9) && !w_op_legal;
  assign w_digit_nz = w_digit && (i_Key_Code != 4'd0);

  // Zero-extend the key code to operand width for the shift-in.
  always_comb begin
    w_key_ext      = '0;
    w_key_ext[3:0] = i_Key_Code;
  end

  // Next-state logic followed by output decode of the next state.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_a_d  = cnt_a_q;
    cnt_b_d  = cnt_b_q;
    op_d     = op_q;
    res_d    = res_q;
    start_d  = 1'b0;
    wd_d     = '0;
    disp_d   = '0;
    blank_d  = '1;
    status_d = 4'b0000;
    err_d    = 1'b0;

    if (i_Clear) begin
      state_d = S_IDLE;
      a_d     = '0;
      b_d     = '0;
      cnt_a_d = '0;
      cnt_b_d = '0;
      op_d    = '0;
      res_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_digit_nz) begin
            a_d     = w_key_ext;
            cnt_a_d = CNT_W'(1);
            b_d     = '0;
            cnt_b_d = '0;
            state_d = S_ENTRY_A;
          end
        end

        S_ENTRY_A: begin
          if (w_op_legal) begin
            op_d    = i_Op_Code;
            b_d     = '0;
            cnt_b_d = '0;
            state_d = S_OP_WAIT;
`ifdef CALC_BACKSPACE_EN
          end else if (i_Back) begin
            a_d     = a_q >> 4;
            cnt_a_d = cnt_a_q - 1'b1;
            if (cnt_a_q == C_ONE) state_d = S_IDLE;
`endif
          end else if (w_digit && (cnt_a_q != C_FULL)) begin
            a_d     = (a_q << 4) | w_key_ext;
            cnt_a_d = cnt_a_q + 1'b1;
          end
        end

        S_OP_WAIT: begin
          if (w_op_legal) begin
            op_d = i_Op_Code;
          end else if (w_digit_nz) begin
            b_d     = w_key_ext;
            cnt_b_d = CNT_W'(1);
            state_d = S_ENTRY_B;
          end
        end

        S_ENTRY_B: begin
          if (i_Equals) begin
            start_d = 1'b1;
            state_d = S_EXEC;
`ifdef CALC_BACKSPACE_EN
          end else if (i_Back) begin
            b_d     = b_q >> 4;
            cnt_b_d = cnt_b_q - 1'b1;
            if (cnt_b_q == C_ONE) state_d = S_OP_WAIT;
`endif
          end else if (w_digit && (cnt_b_q != C_FULL)) begin
            b_d     = (b_q << 4) | w_key_ext;
            cnt_b_d = cnt_b_q + 1'b1;
          end
        end

        S_EXEC: begin
          if (i_Done) begin
            if (i_Overflow) begin
              state_d = S_ERROR;
            end else begin
              res_d   = i_Result;
              state_d = S_SHOW;
            end
          end else if (wd_q == C_TO_LAST) begin
            state_d = S_ERROR;
          end else begin
            wd_d = wd_q + 1'b1;
          end
        end

        S_SHOW: begin
          if (w_op_legal) begin
            a_d     = res_q;
            cnt_a_d = f_sig_digits(res_q);
            op_d    = i_Op_Code;
            b_d     = '0;
            cnt_b_d = '0;
            state_d = S_OP_WAIT;
          end else if (w_digit_nz) begin
            a_d     = w_key_ext;
            cnt_a_d = CNT_W'(1);
            b_d     = '0;
            cnt_b_d = '0;
            state_d = S_ENTRY_A;
          end
        end

        S_ERROR: begin
          state_d = S_ERROR;
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    case (state_d)
      S_IDLE: begin
        disp_d  = a_d;
        blank_d = f_blank_above(cnt_a_d);
      end
      S_ENTRY_A: begin
        disp_d   = a_d;
        blank_d  = f_blank_above(cnt_a_d);
        status_d = 4'b0001;
      end
      S_OP_WAIT: begin
        disp_d   = b_d;
        blank_d  = '1;
        status_d = 4'b0010;
      end
      S_ENTRY_B: begin
        disp_d   = b_d;
        blank_d  = f_blank_above(cnt_b_d);
        status_d = 4'b0010;
      end
      S_EXEC: begin
        disp_d   = b_d;
        blank_d  = f_blank_above(cnt_b_d);
        status_d = 4'b0100;
      end
      S_SHOW: begin
        disp_d   = res_d;
        blank_d  = f_blank_lz(res_d);
        status_d = 4'b1000;
      end
      S_ERROR: begin
        disp_d   = '0;
        blank_d  = '1;
        status_d = 4'b1111;
        err_d    = 1'b1;
      end
      default: begin
        disp_d  = '0;
        blank_d = '1;
      end
    endcase
  end

  // State and registered outputs; reset asserts asynchronously.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      disp_q   <= '0;
      cnt_a_q  <= '0;
      cnt_b_q  <= '0;
      op_q     <= '0;
      start_q  <= 1'b0;
      err_q    <= 1'b0;
      blank_q  <= '1;
      status_q <= 4'b0000;
      wd_q     <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      disp_q   <= disp_d;
      cnt_a_q  <= cnt_a_d;
      cnt_b_q  <= cnt_b_d;
      op_q     <= op_d;
      start_q  <= start_d;
      err_q    <= err_d;
      blank_q  <= blank_d;
      status_q <= status_d;
      wd_q     <= wd_d;
    end
  end

  assign o_Operand_A = a_q;
  assign o_Operand_B = b_q;
  assign o_Op_Code   = op_q;
  assign o_Start     = start_q;
  assign o_Display   = disp_q;
  assign o_Blank     = blank_q;
  assign o_Status    = status_q;
  assign o_Error     = err_q;

endmodule

`default_nettype wire
